// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller driving an external single-step shifter, one step per clock.
// Optional SHIFT_SEQ_FLAGS_EN adds registered carry-out (cout) and zero-result (zero) flags.
`timescale 1ns/1ps
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] op,
    input  logic [SEL_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] shf_word,
    output logic [SEL_W-1:0] shf_sel,
    input  logic [WIDTH-1:0] shf_result
`ifdef SHIFT_SEQ_FLAGS_EN
    ,
    output logic             cout,
    output logic             zero
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SEL_W-1:0] SEL_PASS = SEL_W'(0);

    state_t           state, state_nx;
    logic [WIDTH-1:0] work_q, work_nx;
    logic [SEL_W-1:0] op_q, op_nx;
    logic [SEL_W-1:0] count_q, count_nx;
    logic             load_dout;

    assign shf_word = work_q;

    always_comb begin
        state_nx  = state;
        work_nx   = work_q;
        op_nx     = op_q;
        count_nx  = count_q;
        load_dout = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        shf_sel   = SEL_PASS;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nx  = din;
                    op_nx    = op;
                    count_nx = amount;
                    if (amount == '0) begin
                        state_nx  = DONE;
                        load_dout = 1'b1;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shf_sel  = op_q;
                work_nx  = shf_result;
                count_nx = count_q - 1'b1;
                if (count_q == SEL_W'(1)) begin
                    state_nx  = DONE;
                    load_dout = 1'b1;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SHIFT_SEQ_FLAGS_EN
    // Bit leaving the word on the final step; zero when no step was taken.
    logic cout_nx;
    always_comb begin
        cout_nx = 1'b0;
        if (state == SHIFT) begin
            case (op_q)
                SEL_W'(1), SEL_W'(3):            cout_nx = work_q[WIDTH-1];
                SEL_W'(2), SEL_W'(4), SEL_W'(5): cout_nx = work_q[0];
                default:                         cout_nx = 1'b0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work_q  <= '0;
            op_q    <= '0;
            count_q <= '0;
            dout    <= '0;
`ifdef SHIFT_SEQ_FLAGS_EN
            cout    <= 1'b0;
            zero    <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            work_q  <= work_nx;
            op_q    <= op_nx;
            count_q <= count_nx;
            if (load_dout) begin
                dout <= work_nx;
`ifdef SHIFT_SEQ_FLAGS_EN
                cout <= cout_nx;
                zero <= (work_nx == '0);
`endif
            end
        end
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller sitting directly upstream of the 4-bit combinational shifter (word/sel -> word_out).
- Accepts a shift command (operand, operation, amount 0-7) and drives the shifter one bit-step per clock.
- Feeds the shifter's word_out back into an internal working register until the requested amount is done, then presents the result with a one-cycle done pulse.
- Lets the processor datapath perform multi-bit shifts and rotates with a single-step shifter.

Parameters:
- WIDTH, 4, data word width; must match the shifter word width.
- SEL_W, 3, width of the shifter select and of the amount field.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  SEL_W  shifter operation code for each step.
- amount  input  SEL_W  number of single-bit steps, 0-7.
- din  input  WIDTH  operand.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse, result valid.
- dout  output  WIDTH  registered result; holds its value between commands.
- shf_word  output  WIDTH  to shifter word input (the working register).
- shf_sel  output  SEL_W  to shifter sel input.
- shf_result  input  WIDTH  from shifter word_out.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, dout=0, working reg=0, count=0, shf_sel=000.
- Reset wins over all other inputs and aborts any command in progress; no done is issued for an aborted command.
- Shifter sel encoding, fixed for this block:
  - 000 pass
  - 001 SLL
  - 010 SRL
  - 011 ROL
  - 100 ROR
  - 101 SRA
  - 110 clear
  - 111 pass
- The sequencer passes op through unmodified; it does not interpret it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - shf_sel=000.
  - On start=1: reg<=din, op_q<=op, count<=amount.
  - Next state is SHIFT if amount!=0, else DONE.
  - start=0: stay in IDLE.
- SHIFT:
  - busy=1, shf_word=reg, shf_sel=op_q.
  - Each cycle: reg<=shf_result, count<=count-1.
  - When count==1 this cycle, next state is DONE.
  - Exactly `amount` SHIFT cycles; no modulo reduction (ROR by 5 on 4 bits takes 5 cycles).
- DONE:
  - busy=1, done=1, shf_sel=000.
  - dout<=reg is loaded at DONE entry and is visible while done=1.
  - Next state is IDLE unconditionally.
- Latency: done asserts amount+1 cycles after the cycle start was sampled. Example: amount=0 gives done 1 cycle after start.
- start while busy (SHIFT or DONE): ignored, not queued.
- Back-to-back throughput: a new start is accepted in the IDLE cycle following DONE, so the minimum period is amount+2 cycles.
- op_q and amount are latched at start; input changes during SHIFT have no effect.
- shf_result is consumed combinationally from the external shifter; the path is shf_word -> shifter -> reg within one cycle.

Optional Feature:
- Macro: SHIFT_SEQ_FLAGS_EN.
- When defined, adds two outputs:
  - cout (1): the last bit shifted or rotated out during the final SHIFT step.
    - SLL/ROL: reg[WIDTH-1] before the step.
    - SRL/SRA/ROR: reg[0] before the step.
    - pass/clear: 0.
    - amount=0: 0.
  - zero (1): high when the result == 0.
  - Both are registered together with dout, reset to 0, and hold until the next DONE.
- When not defined, both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- SLL: din=4'b1011, op=001, amount=2 -> shf_sel=001 for 2 cycles; done pulses 3 cycles after start; dout=4'b1100; busy high for 3 cycles.
- ROR no wrap-reduction: din=4'b1001, op=100, amount=5 -> 5 SHIFT cycles; done 6 cycles after start; dout=4'b1100.
- Zero amount: din=4'b0110, amount=0 -> no SHIFT cycles; shf_sel stays 000; done 1 cycle after start; dout=4'b0110.
- SRA then ignored start: din=4'b1000, op=101, amount=3, with start re-pulsed (din=4'b0001) mid-SHIFT -> dout=4'b1111; second start ignored; exactly one done pulse.
- Reset mid-operation: rst=1 during the second SHIFT cycle of an SLL by 4 -> next cycle busy=0, done=0, dout=0, shf_sel=000. A fresh command (din=4'b0011, ROL, amount=1) then yields dout=4'b0110.
- Flags (SHIFT_SEQ_FLAGS_EN defined): din=4'b1011, SLL, amount=1 -> dout=4'b0110, cout=1, zero=0. Then din=4'b1000, SRL, amount=4 -> dout=4'b0000, cout=1, zero=1.
